// File: rtl/ps2_note_pkg.sv
// Shared constants for the PS/2 note decoder: scan codes, note codes, FSM states.
package ps2_note_pkg;

    // Prefix bytes
    localparam logic [7:0] BREAK_PFX = 8'hF0;
    localparam logic [7:0] EXT_PFX   = 8'hE0;

    // Piano-row make codes
    localparam logic [7:0] KEY_C    = 8'h1C;
    localparam logic [7:0] KEY_CS   = 8'h1D;
    localparam logic [7:0] KEY_D    = 8'h1B;
    localparam logic [7:0] KEY_DS   = 8'h24;
    localparam logic [7:0] KEY_E    = 8'h23;
    localparam logic [7:0] KEY_F    = 8'h2B;
    localparam logic [7:0] KEY_FS   = 8'h2C;
    localparam logic [7:0] KEY_G    = 8'h34;
    localparam logic [7:0] KEY_GS   = 8'h35;
    localparam logic [7:0] KEY_A    = 8'h33;
    localparam logic [7:0] KEY_AS   = 8'h3C;
    localparam logic [7:0] KEY_B    = 8'h3B;
    localparam logic [7:0] KEY_HI_C = 8'h42;

    // Octave step keys
    localparam logic [7:0] OCT_DN = 8'h1A;
    localparam logic [7:0] OCT_UP = 8'h22;

    // Note codes
    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    // Prefix-tracking FSM
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

endpackage

// File: rtl/scancode_to_note.sv
// Combinational Set-2 make-code classifier: note keys, high-C key, octave keys.
module scancode_to_note
    import ps2_note_pkg::*;
(
    input  logic [7:0] ps2_byte,
    output logic       is_note,
    output logic [3:0] note,
    output logic       octave_plus1,
    output logic       is_oct_dn,
    output logic       is_oct_up
);

    // Map one scan code to its note or octave-key meaning
    always_comb begin
        is_note      = 1'b1;
        note         = NOTE_C;
        octave_plus1 = 1'b0;
        is_oct_dn    = 1'b0;
        is_oct_up    = 1'b0;
        case (ps2_byte)
            KEY_C:    note = NOTE_C;
            KEY_CS:   note = NOTE_CS;
            KEY_D:    note = NOTE_D;
            KEY_DS:   note = NOTE_DS;
            KEY_E:    note = NOTE_E;
            KEY_F:    note = NOTE_F;
            KEY_FS:   note = NOTE_FS;
            KEY_G:    note = NOTE_G;
            KEY_GS:   note = NOTE_GS;
            KEY_A:    note = NOTE_A;
            KEY_AS:   note = NOTE_AS;
            KEY_B:    note = NOTE_B;
            KEY_HI_C: begin
                note         = NOTE_C;
                octave_plus1 = 1'b1;
            end
            OCT_DN: begin
                is_note   = 1'b0;
                is_oct_dn = 1'b1;
            end
            OCT_UP: begin
                is_note   = 1'b0;
                is_oct_up = 1'b1;
            end
            default:  is_note = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code to note decoder: prefix FSM, octave register, held-key tracking.
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int unsigned DEFAULT_OCTAVE = 4,
    parameter int unsigned MAX_OCTAVE     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    output logic       note_in,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       key_held,
    output logic       note_off
);

    localparam logic [2:0] DEF_OCT = 3'(DEFAULT_OCTAVE);
    localparam logic [2:0] MAX_OCT = 3'(MAX_OCTAVE);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_oct_reg, w_oct_reg_nxt;
    logic [7:0] r_held_code, w_held_code_nxt;
    logic       r_note_in, w_note_in_nxt;
    logic       r_note_off, w_note_off_nxt;
    logic [3:0] r_note, w_note_nxt;
    logic [2:0] r_octave, w_octave_nxt;
    logic       r_key_held, w_key_held_nxt;

    logic       w_is_note;
    logic [3:0] w_map_note;
    logic       w_oct_plus1;
    logic       w_is_oct_dn;
    logic       w_is_oct_up;
    logic       w_is_prefix;

    scancode_to_note u_map (
        .ps2_byte     (ps2_byte),
        .is_note      (w_is_note),
        .note         (w_map_note),
        .octave_plus1 (w_oct_plus1),
        .is_oct_dn    (w_is_oct_dn),
        .is_oct_up    (w_is_oct_up)
    );

    assign w_is_prefix = (ps2_byte == BREAK_PFX) || (ps2_byte == EXT_PFX);

    // State, octave, held-code and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_oct_reg   <= DEF_OCT;
            r_held_code <= '0;
            r_note_in   <= 1'b0;
            r_note_off  <= 1'b0;
            r_note      <= '0;
            r_octave    <= DEF_OCT;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_oct_reg   <= w_oct_reg_nxt;
            r_held_code <= w_held_code_nxt;
            r_note_in   <= w_note_in_nxt;
            r_note_off  <= w_note_off_nxt;
            r_note      <= w_note_nxt;
            r_octave    <= w_octave_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    // Prefix tracking: F0 marks a break, E0 marks an extended key
    always_comb begin
        w_state_nxt = r_state;
        if (ps2_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (ps2_byte == BREAK_PFX)    w_state_nxt = ST_BREAK;
                    else if (ps2_byte == EXT_PFX) w_state_nxt = ST_EXT;
                end
                ST_BREAK: begin
                    if (ps2_byte != BREAK_PFX) w_state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    if (ps2_byte == BREAK_PFX) w_state_nxt = ST_EXT_BREAK;
                    else                       w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Make/break handling: note latch, octave stepping, release detection
    always_comb begin
        w_oct_reg_nxt   = r_oct_reg;
        w_held_code_nxt = r_held_code;
        w_note_in_nxt   = 1'b0;
        w_note_off_nxt  = 1'b0;
        w_note_nxt      = r_note;
        w_octave_nxt    = r_octave;
        w_key_held_nxt  = r_key_held;
        if (ps2_valid) begin
            if (r_state == ST_IDLE && !w_is_prefix) begin
                if (w_is_note) begin
                    if (!(r_key_held && ps2_byte == r_held_code)) begin
                        w_note_in_nxt   = 1'b1;
                        w_note_nxt      = w_map_note;
                        w_key_held_nxt  = 1'b1;
                        w_held_code_nxt = ps2_byte;
                        if (w_oct_plus1 && r_oct_reg < MAX_OCT)
                            w_octave_nxt = r_oct_reg + 3'd1;
                        else if (w_oct_plus1)
                            w_octave_nxt = MAX_OCT;
                        else
                            w_octave_nxt = r_oct_reg;
                    end
                end else if (w_is_oct_dn) begin
                    if (r_oct_reg != 3'd0) w_oct_reg_nxt = r_oct_reg - 3'd1;
                end else if (w_is_oct_up) begin
                    if (r_oct_reg < MAX_OCT) w_oct_reg_nxt = r_oct_reg + 3'd1;
                end
            end else if (r_state == ST_BREAK && ps2_byte != BREAK_PFX) begin
                if (r_key_held && ps2_byte == r_held_code) begin
                    w_note_off_nxt = 1'b1;
                    w_key_held_nxt = 1'b0;
                end
            end
        end
    end

    assign note_in  = r_note_in;
    assign note_off = r_note_off;
    assign note     = r_note;
    assign octave   = r_octave;
    assign key_held = r_key_held;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: per-cycle model compare plus literal checks.
module tb_ps2_note_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic       note_in;
    logic [3:0] note;
    logic [2:0] octave;
    logic       key_held;
    logic       note_off;

    int errors = 0;
    int checks = 0;

    ps2_note_decoder #(
        .DEFAULT_OCTAVE (4),
        .MAX_OCTAVE     (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_byte  (ps2_byte),
        .ps2_valid (ps2_valid),
        .note_in   (note_in),
        .note      (note),
        .octave    (octave),
        .key_held  (key_held),
        .note_off  (note_off)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the keyboard semantics, expressed in terms of key events
    logic [7:0] KEYS [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                              8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    bit m_on = 0;
    bit m_saw_f0, m_saw_e0;
    int m_octreg, m_note, m_oct, m_code;
    bit m_note_in, m_note_off, m_held;

    function automatic int key_index(input logic [7:0] b);
        for (int i = 0; i < 12; i++)
            if (KEYS[i] == b) return i;
        return -1;
    endfunction

    task automatic model_make(input logic [7:0] b);
        int idx;
        bit hi;
        idx = key_index(b);
        hi  = (b == 8'h42);
        if (hi) idx = 0;
        if (idx >= 0) begin
            if (!(m_held && int'(b) == m_code)) begin
                m_note_in = 1;
                m_note    = idx;
                m_oct     = hi ? ((m_octreg + 1 > 6) ? 6 : m_octreg + 1) : m_octreg;
                m_held    = 1;
                m_code    = int'(b);
            end
        end else if (b == 8'h1A) begin
            m_octreg = (m_octreg > 0) ? m_octreg - 1 : 0;
        end else if (b == 8'h22) begin
            m_octreg = (m_octreg < 6) ? m_octreg + 1 : 6;
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit rst);
        m_note_in  = 0;
        m_note_off = 0;
        if (rst) begin
            m_on = 1; m_saw_f0 = 0; m_saw_e0 = 0;
            m_octreg = 4; m_note = 0; m_oct = 4; m_held = 0; m_code = 0;
        end else if (v) begin
            if (m_saw_e0) begin
                if (b == 8'hF0 && !m_saw_f0) m_saw_f0 = 1;
                else begin m_saw_e0 = 0; m_saw_f0 = 0; end
            end else if (m_saw_f0) begin
                if (b != 8'hF0) begin
                    m_saw_f0 = 0;
                    if (m_held && int'(b) == m_code) begin
                        m_note_off = 1;
                        m_held     = 0;
                    end
                end
            end else if (b == 8'hF0) m_saw_f0 = 1;
            else if (b == 8'hE0) m_saw_e0 = 1;
            else model_make(b);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (m_on) begin
            check("model_note_in",  int'(note_in),  int'(m_note_in));
            check("model_note_off", int'(note_off), int'(m_note_off));
            check("model_key_held", int'(key_held), int'(m_held));
            check("model_note",     int'(note),     m_note);
            check("model_octave",   int'(octave),   m_oct);
        end
    end

    // One clock cycle of stimulus; returns at the negedge after the edge that consumed it
    task automatic tick(input bit v, input logic [7:0] b, input bit rst);
        #1;
        reset     = rst;
        ps2_valid = v;
        ps2_byte  = b;
        model_step(v, b, rst);
        @(negedge clk);
        #1;
        reset     = 1'b0;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
        @(negedge clk);
        tick(1'b0, 8'h00, 1'b1);
        check("rst_note_in",  int'(note_in),  0);
        check("rst_note_off", int'(note_off), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_note",     int'(note),     0);
        check("rst_octave",   int'(octave),   4);
        idle();

        // First note
        send(8'h1C);
        check("c_note_in",  int'(note_in),  1);
        check("c_note",     int'(note),     0);
        check("c_octave",   int'(octave),   4);
        check("c_key_held", int'(key_held), 1);
        idle();
        check("c_pulse_end", int'(note_in), 0);

        // Typematic repeat then release
        send(8'h1C);
        check("rep1_note_in", int'(note_in), 0);
        send(8'h1C);
        check("rep2_note_in", int'(note_in), 0);
        send(8'hF0);
        send(8'h1C);
        check("rel_note_off", int'(note_off), 1);
        check("rel_key_held", int'(key_held), 0);
        check("rel_note",     int'(note),     0);
        idle();
        check("rel_pulse_end", int'(note_off), 0);

        // Octave saturation up
        for (int i = 0; i < 4; i++) send(8'h22);
        send(8'h33);
        check("up_octave", int'(octave), 6);
        check("up_note",   int'(note),   9);
        send(8'hF0); send(8'h33);

        // Octave saturation down, then high C
        for (int i = 0; i < 8; i++) send(8'h1A);
        send(8'h42);
        check("hic_note_in", int'(note_in), 1);
        check("hic_octave",  int'(octave),  1);
        check("hic_note",    int'(note),    0);
        send(8'hF0); send(8'h42);

        // Key steal
        send(8'h34);
        check("steal1_note_in", int'(note_in), 1);
        send(8'h3B);
        check("steal2_note_in",  int'(note_in),  1);
        check("steal2_note",     int'(note),     11);
        check("steal2_note_off", int'(note_off), 0);
        send(8'hF0); send(8'h34);
        check("stale_brk_off",  int'(note_off), 0);
        check("stale_brk_held", int'(key_held), 1);
        send(8'hF0); send(8'h3B);
        check("steal_rel_off", int'(note_off), 1);

        // Extended and unmapped bytes
        send(8'hE0); send(8'h1C);
        check("ext_note_in", int'(note_in), 0);
        send(8'hE0); send(8'hF0); send(8'h1C);
        check("extbrk_note_in",  int'(note_in),  0);
        check("extbrk_note_off", int'(note_off), 0);
        send(8'h15);
        check("unmap_note_in", int'(note_in), 0);
        send(8'h1C);
        check("post_ext_note_in", int'(note_in), 1);
        check("post_ext_octave",  int'(octave),  0);
        send(8'hF0); send(8'h1C);

        // Reset mid-operation with a coincident strobe
        send(8'h22); send(8'h22);
        send(8'h2B);
        check("pre_rst_note",   int'(note),   5);
        check("pre_rst_octave", int'(octave), 2);
        tick(1'b1, 8'h1C, 1'b1);
        check("mid_rst_note_in",  int'(note_in),  0);
        check("mid_rst_key_held", int'(key_held), 0);
        check("mid_rst_note",     int'(note),     0);
        check("mid_rst_octave",   int'(octave),   4);
        send(8'h1C);
        check("post_rst_note_in", int'(note_in), 1);
        check("post_rst_octave",  int'(octave),  4);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
Name: ps2_note_decoder

Overview:
- Sits upstream of the synth controller and drives its note_in / note / octave inputs.
- Consumes PS/2 Set-2 scan-code bytes from the keyboard byte receiver and tracks make/break/extended prefixes.
- Maps a piano-style key row to a note, and keeps an octave register that the octave keys step up and down.
- Emits a one-cycle note_in strobe with stable note/octave, plus held and release indications for the envelope's release phase.

Parameters:
- DEFAULT_OCTAVE, 4, octave value loaded at reset; 4 is middle-C octave.
- MAX_OCTAVE, 6, upper saturation limit of the octave register; the lower limit is 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_byte  in  8  received scan-code byte
- ps2_valid  in  1  one-cycle strobe; ps2_byte is valid in that cycle
- note_in  out  1  one-cycle pulse: a new note was pressed
- note  out  4  note code 0..11 (C=0, C#=1, ..., B=11)
- octave  out  3  octave of the latched note
- key_held  out  1  high while the latched note key is physically down
- note_off  out  1  one-cycle pulse when the held note key is released

Behaviour:
- Reset (clk edge with reset=1):
  - note_in=0, note_off=0, key_held=0, note=0, octave=DEFAULT_OCTAVE.
  - Octave register = DEFAULT_OCTAVE; held-code register = 0x00; FSM = IDLE.
  - Reset overrides a coincident ps2_valid.
- Bytes are processed only in cycles with ps2_valid=1. All outputs are registered, so responses appear in the cycle after the strobe.
- Key map (Set-2 make codes):
  - 1C=C, 1D=C#, 1B=D, 24=D#, 23=E, 2B=F, 2C=F#, 34=G, 35=G#, 33=A, 3C=A#, 3B=B.
  - 42 (K) = C at octave register+1, saturated at MAX_OCTAVE.
  - 1A (Z) = octave down; 22 (X) = octave up.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK.
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is handled as a make code and the FSM stays in IDLE.
  - BREAK: the next byte is a break code; F0 stays in BREAK, any other byte -> IDLE.
  - EXT: F0 -> EXT_BREAK; any other byte -> IDLE, and the byte is ignored.
  - EXT_BREAK: any byte -> IDLE, and the byte is ignored. Extended keys never affect notes.
- Make of a note key:
  - If key_held=1 and the byte equals the held code, it is a typematic repeat: no pulse, no change.
  - Otherwise, next cycle: note_in=1; note and octave load the mapped value; key_held=1; the held code loads the byte.
  - A new note key pressed while another is held steals it (last-key priority). note_in pulses and note_off does not.
- Make of Z/X:
  - The octave register decrements/increments, saturating at 0 / MAX_OCTAVE.
  - No note_in pulse; the already-latched octave output is unchanged until the next note.
  - Typematic repeats of Z/X step repeatedly, which is acceptable.
- Break of a byte equal to the held code while key_held=1: next cycle note_off=1 and key_held=0. note/octave hold their values.
- Break of any other code: ignored.
- Unmapped make codes: ignored.
- note/octave are valid in the note_in cycle and remain stable until the next note_in.
- Pulse width: note_in and note_off are exactly one cycle and are never asserted together.

Decomposition:
- Shared package ps2_note_pkg holds:
  - Scan-code constants: BREAK_PFX=8'hF0, EXT_PFX=8'hE0, the key codes above, OCT_DN, OCT_UP.
  - Note-code localparams NOTE_C..NOTE_B.
  - FSM state encoding (2-bit).
- Sub-module scancode_to_note: purely combinational lookup.
  - Inputs: ps2_byte.
  - Outputs: is_note, note[3:0], octave_plus1 (set for K), is_oct_dn, is_oct_up.
- The top level keeps the FSM, the octave register, the held-code register and the output registers.

Test Plan:
- Reset, then bytes 1C -> one cycle after the strobe: note_in=1, note=0, octave=4, key_held=1; note_in=0 the following cycle.
- Hold repeat: 1C, 1C, 1C -> exactly one note_in pulse; then F0,1C -> note_off=1 for one cycle, key_held=0, note stays 0.
- Octave saturation: X sent 4 times, then 33 -> octave=6, note=9. Then Z sent 8 times, then 42 -> octave=1, note=0.
- Key steal: 34 then 3B without a break -> two note_in pulses, final note=11, no note_off. Then F0,34 -> ignored, key_held stays 1. Then F0,3B -> note_off.
- Extended/unmapped: E0,1C and E0,F0,1C and 15 -> no output activity. Following 1C -> a normal note_in.
- Reset mid-operation: after X,X and a held 2B, assert reset with ps2_valid=1 and byte 1C -> all outputs at reset values, octave=4, no note_in; next 1C -> octave=4.
